// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
//   Shared definitions for the DDS note synthesiser:
//   - default clock frequency used to build the tuning-word table
//   - note frequencies in centi-Hz (C4..C5)
//   - constant function computing a rounded frequency tuning word
//   - FSM state encoding
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int unsigned DEF_CLK_HZ = 2_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PEND   = 2'd2,
        MUTING = 2'd3
    } state_e;

    // Note frequency in hundredths of a Hz: C4 D4 E4 F4 G4 A4 B4 C5.
    function automatic logic [31:0] note_chz(input logic [2:0] idx);
        logic [31:0] f;
        case (idx)
            3'd0:    f = 32'd26163;
            3'd1:    f = 32'd29366;
            3'd2:    f = 32'd32963;
            3'd3:    f = 32'd34923;
            3'd4:    f = 32'd39200;
            3'd5:    f = 32'd44000;
            3'd6:    f = 32'd49388;
            default: f = 32'd52325;
        endcase
        return f;
    endfunction

    // round(f * 2**acc_w / clk_hz), with f held in centi-Hz.
    function automatic logic [63:0] ftw_calc(input logic [2:0]  idx,
                                             input int unsigned acc_w,
                                             input int unsigned clk_hz);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] quo;
        num = {96'd0, note_chz(idx)} << acc_w;
        den = {96'd0, clk_hz} * 128'd100;
        quo = (num + (den >> 1)) / den;
        return quo[63:0];
    endfunction

endpackage

// File: rtl/dds_ftw_rom.sv
// -----------------------------------------------------------------------------
// dds_ftw_rom
//   Combinational note/octave to frequency-tuning-word lookup. The table is
//   built at elaboration from dds_pkg::ftw_calc for the given clock frequency.
// Ports:
//   note_bin_i  note index (only the low 3 bits select a distinct note)
//   octave_i    left shift 0..3 applied to the base tuning word
//   ftw_o       resulting tuning word, truncated to ACC_W bits
// -----------------------------------------------------------------------------
module dds_ftw_rom
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned NOTE_W = 3,
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic [NOTE_W-1:0] note_bin_i,
    input  logic [1:0]        octave_i,
    output logic [ACC_W-1:0]  ftw_o
);

    localparam int unsigned DEPTH = 2 ** NOTE_W;

    logic [ACC_W-1:0] tab [DEPTH];

    // Entries beyond the eight defined notes alias onto them (index mod 8).
    for (genvar i = 0; i < DEPTH; i++) begin : g_tab
        localparam logic [63:0] FTW_I = ftw_calc(3'(i), ACC_W, CLK_HZ);
        assign tab[i] = FTW_I[ACC_W-1:0];
    end

    assign ftw_o = tab[note_bin_i] << octave_i;

endmodule

// File: rtl/dds_note_synth.sv
// -----------------------------------------------------------------------------
// dds_note_synth
//   Phase-accumulator DDS tone generator. A note index and octave select a
//   tuning word; note changes while running are held pending and applied on
//   the accumulator carry-out so the tone never glitches mid-period.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   note_bin     note index 0..7 = C4 D4 E4 F4 G4 A4 B4 C5
//   octave       tuning-word left shift 0..3
//   note_valid   note request; accepted when note_ready is also high
//   note_ready   block can accept a note (low while muted or pending)
//   mute         level: silence the tone at the next wrap
//   tone_out     square tone, phase MSB
//   phase        registered accumulator value
//   wrap         registered one-cycle pulse on accumulator carry-out
//   amp          amplitude derived combinationally from phase
// Configuration:
//   DDS_TRI_OUT_EN defined   -> amp is a triangle
//   DDS_TRI_OUT_EN undefined -> amp is a sawtooth
// -----------------------------------------------------------------------------
module dds_note_synth
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned NOTE_W = 3,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note_bin,
    input  logic [1:0]        octave,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic              mute,
    output logic              tone_out,
    output logic [ACC_W-1:0]  phase,
    output logic              wrap,
    output logic [OUT_W-1:0]  amp
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic             wrap_q, wrap_d;
    logic             rdy_en_q;

    logic [ACC_W-1:0] rom_ftw;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;

    dds_ftw_rom #(
        .ACC_W  (ACC_W),
        .NOTE_W (NOTE_W),
        .CLK_HZ (CLK_HZ)
    ) u_rom (
        .note_bin_i (note_bin),
        .octave_i   (octave),
        .ftw_o      (rom_ftw)
    );

    assign sum   = {1'b0, phase_q} + {1'b0, ftw_q};
    assign carry = sum[ACC_W];

    // rdy_en_q keeps note_ready low during reset and releases it on the first
    // clock edge afterwards.
    assign note_ready = rdy_en_q && !mute && (state_q != PEND);
    assign accept     = note_valid && note_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            ftw_q    <= '0;
            pend_q   <= '0;
            wrap_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ftw_q    <= ftw_d;
            pend_q   <= pend_d;
            wrap_q   <= wrap_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state logic; mute always takes priority over a pending note.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (mute)        state_d = MUTING;
                else if (accept) state_d = PEND;
            end
            PEND: begin
                if (mute)       state_d = MUTING;
                else if (carry) state_d = RUN;
            end
            MUTING: begin
                if (carry)      state_d = IDLE;
                else if (!mute) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        phase_d = sum[ACC_W-1:0];
        ftw_d   = ftw_q;
        pend_d  = pend_q;
        wrap_d  = carry;
        if (accept) pend_d = rom_ftw;
        case (state_q)
            IDLE: begin
                // Load straight from the ROM so the tone starts on the next edge.
                phase_d = '0;
                wrap_d  = 1'b0;
                if (accept) ftw_d = rom_ftw;
            end
            PEND: begin
                // The carry edge still uses the old word; the new one runs after it.
                if (!mute && carry) ftw_d = pend_q;
            end
            MUTING: begin
                if (carry) begin
                    ftw_d   = '0;
                    phase_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign phase    = phase_q;
    assign wrap     = wrap_q;
    assign tone_out = phase_q[ACC_W-1];

`ifdef DDS_TRI_OUT_EN
    // Fold the second half of the period down to form a triangle.
    assign amp = phase_q[ACC_W-1] ? ~phase_q[ACC_W-2 -: OUT_W] : phase_q[ACC_W-2 -: OUT_W];
`else
    assign amp = phase_q[ACC_W-1 -: OUT_W];
`endif

endmodule
